bcd2bin_seq: RTL

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

---
 rtl/bcd2bin_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble, one bit per cycle.
// Optional invalid-digit detection is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  BCD3,
    input  logic [3:0]  BCD2,
    input  logic [3:0]  BCD1,
    input  logic [3:0]  BCD0,
    output logic [13:0] BIN,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'd13;

    state_t      state;
    logic [15:0] digits;
    logic [13:0] result;
    logic [3:0]  count;
    logic [15:0] digits_next;
    logic [13:0] result_next;

    // Shift right one bit, then pull any digit that reached 8 back down by 3.
    function automatic logic [15:0] dabble_step(input logic [15:0] d);
        logic [15:0] s;
        s = d >> 1;
        for (int unsigned k = 0; k < 4; k++) begin
            if (s[4*k +: 4] >= 4'd8) begin
                s[4*k +: 4] = s[4*k +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    always_comb begin
        digits_next = dabble_step(digits);
        result_next = {digits[0], result[13:1]};
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic bad;
    logic in_bad;

    always_comb begin
        in_bad = (BCD3 > 4'd9) || (BCD2 > 4'd9) || (BCD1 > 4'd9) || (BCD0 > 4'd9);
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            digits <= '0;
            result <= '0;
            count  <= '0;
            BIN    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad    <= 1'b0;
            err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        digits <= {BCD3, BCD2, BCD1, BCD0};
                        result <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                        bad    <= in_bad;
                        err    <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    // Invalid input spends a single SHIFT cycle and completes with an error.
                    if (bad) begin
                        BIN   <= '0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        bad   <= 1'b0;
                        state <= IDLE;
                    end else begin
`else
                    begin
`endif
                        digits <= digits_next;
                        result <= result_next;
                        count  <= count + 4'd1;
                        if (count == LAST_STEP) begin
                            BIN   <= result_next;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
